data_mem_mmio: RTL

Data-side memory system fed by the core's memory stage. Takes the core's memory-access outputs (write enable, ALU address, store data) and returns load data in the same cycle, so the result is captured by the MEM/WB register at the next edge. It contains a word-addressed data RAM and a small memory-mapped I/O page. The I/O page holds a byte transmit FIFO with a valid/ready drain port, and a free-running cycle timer with a compare interrupt.

---
 rtl/data_mem_mmio_if.sv | 22 ++
 rtl/data_mem_mmio.sv | 122 ++++++++++++
 2 files changed

// File: rtl/data_mem_mmio_if.sv
// Bus between the core memory stage and the data-side memory system,
// plus the TX drain port and the timer interrupt line.
interface data_mem_mmio_if;
  logic        mem_write_mem;
  logic [31:0] alu_result_mem;
  logic [31:0] write_data_mem;
  logic [31:0] read_data_mem;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        timer_irq;

  modport master (
    output mem_write_mem, alu_result_mem, write_data_mem, tx_ready,
    input  read_data_mem, tx_data, tx_valid, timer_irq
  );

  modport slave (
    input  mem_write_mem, alu_result_mem, write_data_mem, tx_ready,
    output read_data_mem, tx_data, tx_valid, timer_irq
  );
endinterface

// File: rtl/data_mem_mmio.sv
// Word-addressed data RAM plus a small MMIO page: a byte TX FIFO with a
// valid/ready drain port and a free-running timer with a sticky compare flag.
module data_mem_mmio #(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_mmio_if.slave  bus
);
  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam logic [FIFO_AW:0] FIFO_FULL = FIFO_DEPTH[FIFO_AW:0];

  typedef enum logic [1:0] {
    REG_TX_DATA   = 2'd0,
    REG_STATUS    = 2'd1,
    REG_TIMER     = 2'd2,
    REG_TIMER_CMP = 2'd3
  } mmio_reg_e;

  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              ram_sel;
  logic              mmio_sel;
  mmio_reg_e         reg_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_bits;

  assign addr             = bus.alu_result_mem;
  assign wdata            = bus.write_data_mem;
  assign ram_sel          = (addr[31:28] == 4'h0);
  assign mmio_sel         = (addr[31:4] == 28'h1000000);
  assign reg_sel          = mmio_reg_e'(addr[3:2]);
  assign ram_idx          = addr[RAM_AW+1:2];
  assign unused_addr_bits = ^addr[1:0];

  logic wr_ram, wr_tx, wr_status, wr_timer, wr_cmp;
  assign wr_ram    = bus.mem_write_mem && ram_sel;
  assign wr_tx     = bus.mem_write_mem && mmio_sel && (reg_sel == REG_TX_DATA);
  assign wr_status = bus.mem_write_mem && mmio_sel && (reg_sel == REG_STATUS);
  assign wr_timer  = bus.mem_write_mem && mmio_sel && (reg_sel == REG_TIMER);
  assign wr_cmp    = bus.mem_write_mem && mmio_sel && (reg_sel == REG_TIMER_CMP);

  // ---------------- data RAM ----------------
  logic [31:0] ram [RAM_WORDS];

  // NOTE: storage arrays carry no reset; a reset loop over a RAM would stop it mapping to block memory.
  always_ff @(posedge clk) begin
    if (reset && wr_ram) ram[ram_idx] <= wdata;
  end

  // ---------------- TX FIFO + timer state ----------------
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               overflow;
  logic [31:0]        timer, timer_cmp;
  logic               irq;

  logic empty, full, pop, push, overflow_set, overflow_clr, irq_set, irq_clr;
  assign empty        = (count == '0);
  assign full         = (count == FIFO_FULL);
  assign pop          = !empty && bus.tx_ready;
  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign push         = wr_tx && (!full || pop);
  assign overflow_set = wr_tx && full && !pop;
  assign overflow_clr = wr_status && wdata[2];
  assign irq_set      = (timer == timer_cmp);
  assign irq_clr      = (wr_status && wdata[3]) || wr_cmp;

  always_ff @(posedge clk) begin
    if (reset && push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  // NOTE: every sequential assignment is non-blocking so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      timer     <= '0;
      timer_cmp <= 32'hFFFF_FFFF;
      irq       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (overflow_set)      overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
      timer <= wr_timer ? wdata : timer + 32'd1;
      if (wr_cmp) timer_cmp <= wdata;
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

  // ---------------- outputs ----------------
  assign bus.tx_valid  = !empty;
  assign bus.tx_data   = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign bus.timer_irq = irq;

  // NOTE: the read mux assigns its default first so no path can infer a latch.
  always_comb begin
    bus.read_data_mem = 32'h0;
    if (ram_sel) begin
      bus.read_data_mem = ram[ram_idx];
    end else if (mmio_sel) begin
      case (reg_sel)
        REG_STATUS:    bus.read_data_mem = {16'h0, 8'(count), 4'h0, irq, overflow, full, empty};
        REG_TIMER:     bus.read_data_mem = timer;
        REG_TIMER_CMP: bus.read_data_mem = timer_cmp;
        default:       bus.read_data_mem = 32'h0;
      endcase
    end
  end
endmodule
